// File: rtl/pwm_array.sv
// pwm_array -- multi-channel PWM generator sharing one prescaled counter.
//
// The counter runs edge-aligned (0..MAX, wrap) or centre-aligned
// (0..MAX, MAX-1..1, back to 0). The run-time mode selection is picked up
// at period start. Each channel's duty is written into a shadow register
// through a valid/ready port. Shadow values are copied into the active
// registers at each period boundary, and continuously while start is low.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     run enable; low holds the counter at 0 and forces outputs low
//   mode      0 = edge-aligned, 1 = centre-aligned (taken at period start)
//   prescale  counter advances once every prescale+1 clocks
//   wr_valid  duty write request
//   wr_ready  write accepted on wr_valid & wr_ready
//   wr_ch     target channel; indices >= STAGE are accepted and dropped
//   wr_duty   duty value
//   hsync     one-clock pulse in the first cycle of each period after a wrap
//   out       registered PWM outputs, out[i] = active[i] > count
//
// Optional build macro PWM_PHASE_STAGGER_EN: in edge mode, channel i
// compares against count + i*(2^DWIDTH/STAGE) (mod 2^DWIDTH), which spreads
// the channel edges across the period. Centre mode is unaffected.
module pwm_array #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned STAGE      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          mode,
  input  logic [PRESCALE_W-1:0]                         prescale,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic [((STAGE > 1) ? $clog2(STAGE) : 1)-1:0]  wr_ch,
  input  logic [DWIDTH-1:0]                             wr_duty,
  output logic                                          hsync,
  output logic [STAGE-1:0]                              out
);

  localparam int unsigned CHW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] MAX = '1;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int unsigned STAGGER_STEP = (2 ** DWIDTH) / STAGE;
`endif

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_e;

  logic [DWIDTH-1:0]     count_q, count_d, count_step;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] presc_lim_q, presc_lim_d;
  dir_e                  dir_q, dir_d, dir_step;
  mode_e                 mode_q, mode_d;
  logic [DWIDTH-1:0]     shadow_q [STAGE];
  logic [DWIDTH-1:0]     shadow_d [STAGE];
  logic [DWIDTH-1:0]     active_q [STAGE];
  logic [DWIDTH-1:0]     active_d [STAGE];
  logic [STAGE-1:0]      out_q, out_d;
  logic                  hsync_q, hsync_d;
  logic                  ready_q, ready_d;
  logic                  tick;
  logic                  wrap_pending;
  logic                  wr_fire;

  // Tick, next count value and the wrap-pending qualifier.
  // The prescale reload value is latched at each reload so that a
  // mid-count change of prescale only affects the next prescaler cycle.
  always_comb begin
    tick       = start & (presc_q == presc_lim_q);
    count_step = count_q + DWIDTH'(1);
    dir_step   = dir_q;
    if (mode_q == MODE_CENTRE) begin
      if (dir_q == DIR_DOWN) begin
        count_step = count_q - DWIDTH'(1);
      end else if (count_q == MAX) begin
        count_step = MAX - DWIDTH'(1);
        dir_step   = DIR_DOWN;
      end
    end
    wrap_pending = tick & (count_step == '0);
    wr_ready     = ready_q & ~wrap_pending;
    wr_fire      = wr_valid & wr_ready;
  end

  always_comb begin
    count_d     = count_q;
    presc_d     = presc_q;
    presc_lim_d = presc_lim_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    hsync_d     = wrap_pending;
    ready_d     = 1'b1;
    for (int unsigned i = 0; i < STAGE; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_fire && (wr_ch == CHW'(i))) begin
        shadow_d[i] = wr_duty;
      end
    end

    if (!start) begin
      // Idle: counter parked at period start, active duties and mode
      // follow the shadow state every cycle.
      count_d     = '0;
      presc_d     = '0;
      presc_lim_d = prescale;
      dir_d       = DIR_UP;
      mode_d      = mode_e'(mode);
      for (int unsigned i = 0; i < STAGE; i++) begin
        active_d[i] = shadow_q[i];
      end
    end else begin
      if (tick) begin
        presc_d     = '0;
        presc_lim_d = prescale;
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
      if (wrap_pending) begin
        count_d = '0;
        dir_d   = DIR_UP;
        mode_d  = mode_e'(mode);
        for (int unsigned i = 0; i < STAGE; i++) begin
          active_d[i] = shadow_q[i];
        end
      end else if (tick) begin
        count_d = count_step;
        dir_d   = dir_step;
      end
    end
  end

  // Per-channel comparators.
  always_comb begin
    logic [DWIDTH-1:0] cmp;
    out_d = '0;
    for (int unsigned i = 0; i < STAGE; i++) begin
      cmp = count_q;
`ifdef PWM_PHASE_STAGGER_EN
      if (mode_q == MODE_EDGE) begin
        cmp = count_q + DWIDTH'(i * STAGGER_STEP);
      end
`endif
      out_d[i] = start & (active_q[i] > cmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      presc_q     <= '0;
      presc_lim_q <= '0;
      dir_q       <= DIR_UP;
      mode_q      <= MODE_EDGE;
      out_q       <= '0;
      hsync_q     <= 1'b0;
      ready_q     <= 1'b0;
      for (int unsigned i = 0; i < STAGE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      presc_q     <= presc_d;
      presc_lim_q <= presc_lim_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      hsync_q     <= hsync_d;
      ready_q     <= ready_d;
      for (int unsigned i = 0; i < STAGE; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign out   = out_q;
  assign hsync = hsync_q;

endmodule
